tx_arbiter_request_collector: RTL and testbench

Upstream feeder of the TX arbiter's sequence recorder. Takes one-cycle "new TLP ready" pulses from the four TX sources and keeps a pending count per source. Each cycle it writes up to four source IDs into the recorder, bounded by the recorder's free space and granted in rotating order. Arrival order is preserved per source, no request is ever lost silently, and no source can starve another.

---
 rtl/tx_arbiter_request_collector_pkg.sv | 36 +++
 rtl/tx_arbiter_request_collector_rr_packer.sv | 57 +++++
 rtl/tx_arbiter_request_collector.sv | 135 +++++++++++++
 tb/tb_tx_arbiter_request_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_request_collector_pkg.sv
// ----------------------------------------------------------------------------
// tx_arbiter_request_collector_pkg
//
// Shared types for the TX arbiter request collector and its round-robin
// packer.
//   NUM_TX_SOURCES       : number of TX sources feeding the arbiter.
//   Tx_Arbiter_Sources_t : 3-bit source ID written into the sequence recorder.
//                          NO_SOURCE marks an unused write slot.
//   src_from_index()     : maps request bit index 0..3 to its source ID.
// ----------------------------------------------------------------------------
package tx_arbiter_request_collector_pkg;

  localparam int NUM_TX_SOURCES = 4;

  typedef enum logic [2:0] {
    NO_SOURCE = 3'd0,
    A2P_1     = 3'd1,
    A2P_2     = 3'd2,
    MASTER    = 3'd3,
    RX_ROUTER = 3'd4
  } Tx_Arbiter_Sources_t;

  // Request bit i belongs to source ID i+1. The explicit case keeps the
  // mapping readable even if the enum encoding ever changes.
  function automatic Tx_Arbiter_Sources_t src_from_index(input logic [1:0] idx);
    Tx_Arbiter_Sources_t src;
    case (idx)
      2'd0:    src = A2P_1;
      2'd1:    src = A2P_2;
      2'd2:    src = MASTER;
      default: src = RX_ROUTER;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/tx_arbiter_request_collector_rr_packer.sv
// ----------------------------------------------------------------------------
// tx_rr_packer
//
// Purely combinational round-robin packer. Scans the eligible mask starting
// at the round-robin pointer (wrapping mod 4) and packs the first i_limit
// eligible sources into consecutive output slots, in scan order.
//
// Ports
//   i_eligible : per-source "has pending work" mask.
//   i_rr_ptr   : index where the scan starts.
//   i_limit    : maximum number of IDs to issue this cycle (0..4). The caller
//                guarantees it never exceeds the number of eligible sources.
//   o_ids      : packed source IDs, slot 0 first; unused slots = NO_SOURCE.
//   o_issued   : per-source mask of the sources placed into a slot.
//   o_count    : number of IDs actually issued.
//   o_next_rr  : index after the last issued source; i_rr_ptr if none.
// ----------------------------------------------------------------------------
module tx_rr_packer
  import tx_arbiter_request_collector_pkg::*;
(
  input  logic [NUM_TX_SOURCES-1:0]                      i_eligible,
  input  logic [1:0]                                     i_rr_ptr,
  input  logic [2:0]                                     i_limit,
  output Tx_Arbiter_Sources_t [NUM_TX_SOURCES-1:0]       o_ids,
  output logic [NUM_TX_SOURCES-1:0]                      o_issued,
  output logic [2:0]                                     o_count,
  output logic [1:0]                                     o_next_rr
);

  logic [1:0] w_idx;
  logic [2:0] w_cnt;

  always_comb begin
    for (int j = 0; j < NUM_TX_SOURCES; j++) begin
      o_ids[j] = NO_SOURCE;
    end
    o_issued  = '0;
    o_next_rr = i_rr_ptr;
    w_idx     = '0;
    w_cnt     = '0;

    // Unrolled scan: offset k visits source (rr_ptr + k) mod 4. The 2-bit
    // addition wraps naturally.
    for (int k = 0; k < NUM_TX_SOURCES; k++) begin
      w_idx = i_rr_ptr + 2'(k);
      if (i_eligible[w_idx] && (w_cnt < i_limit)) begin
        o_ids[w_cnt[1:0]] = src_from_index(w_idx);
        o_issued[w_idx]   = 1'b1;
        o_next_rr         = w_idx + 2'd1;
        w_cnt             = w_cnt + 3'd1;
      end
    end

    o_count = w_cnt;
  end

endmodule

// File: rtl/tx_arbiter_request_collector.sv
// ----------------------------------------------------------------------------
// tx_arbiter_request_collector
//
// Upstream feeder of the TX arbiter's sequence recorder. Counts one-cycle
// "new TLP ready" pulses per source and, every cycle, writes up to four
// source IDs into the recorder in rotating order, bounded by the recorder's
// free space. At most one ID per source per cycle, so per-source arrival
// order is kept and no source can starve another.
//
// Handshake: a pulse on i_req_valid[i] is accepted when o_req_ready[i] is
// high in the same cycle (ready depends on registered state only). A pulse
// while ready is low is dropped and sets the sticky o_overflow_err.
// A recorder write is a single-cycle o_rec_wr_en strobe with no back
// pressure: it is only issued when the recorder has room for all of it.
//
// Ports
//   i_clk, i_arst            : clock, asynchronous active-high reset.
//   i_req_valid[3:0]         : pulses; bit 0 A2P_1, 1 A2P_2, 2 MASTER,
//                              3 RX_ROUTER.
//   o_req_ready[3:0]         : source i's pending counter is not saturated.
//   i_rec_available          : recorder free locations (registered count).
//   i_rec_full               : recorder full.
//   o_rec_wr_en              : write strobe.
//   o_rec_wr_mode            : number of IDs written (1..4), 0 when idle.
//   o_rec_wr_data_1..4       : IDs in grant order; unused = NO_SOURCE.
//   o_overflow_err           : sticky dropped-pulse flag.
//   o_dbg_rr_ptr             : round-robin pointer, for observation only.
// ----------------------------------------------------------------------------
module tx_arbiter_request_collector
  import tx_arbiter_request_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 10,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int PEND_WIDTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic [NUM_TX_SOURCES-1:0]     i_req_valid,
  output logic [NUM_TX_SOURCES-1:0]     o_req_ready,
  input  logic [ADDR_WIDTH:0]           i_rec_available,
  input  logic                          i_rec_full,
  output logic                          o_rec_wr_en,
  output logic [2:0]                    o_rec_wr_mode,
  output Tx_Arbiter_Sources_t           o_rec_wr_data_1,
  output Tx_Arbiter_Sources_t           o_rec_wr_data_2,
  output Tx_Arbiter_Sources_t           o_rec_wr_data_3,
  output Tx_Arbiter_Sources_t           o_rec_wr_data_4,
  output logic                          o_overflow_err,
  output logic [1:0]                    o_dbg_rr_ptr
);

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  // State
  logic [PEND_WIDTH-1:0] r_pending [NUM_TX_SOURCES];
  logic [1:0]            r_rr_ptr;
  logic                  r_overflow;

  // Issue decision
  logic [NUM_TX_SOURCES-1:0]                w_eligible;
  logic [NUM_TX_SOURCES-1:0]                w_ready;
  logic [NUM_TX_SOURCES-1:0]                w_accept;
  logic [2:0]                               w_elig_cnt;
  logic [2:0]                               w_limit;
  Tx_Arbiter_Sources_t [NUM_TX_SOURCES-1:0] w_ids;
  logic [NUM_TX_SOURCES-1:0]                w_issued;
  logic [2:0]                               w_count;
  logic [1:0]                               w_next_rr;

  always_comb begin
    w_elig_cnt = '0;
    for (int i = 0; i < NUM_TX_SOURCES; i++) begin
      w_eligible[i] = (r_pending[i] != '0);
      w_ready[i]    = (r_pending[i] != PEND_MAX);
      w_elig_cnt    = w_elig_cnt + 3'(w_eligible[i]);
    end
    w_accept = i_req_valid & w_ready;
  end

  // n = min(eligible count, available space); the eligible count is at most
  // four so that bound is implicit. A full recorder forces zero, and an
  // inconsistent available == 0 with full == 0 falls out of the min as zero.
  always_comb begin
    w_limit = w_elig_cnt;
    if (32'(i_rec_available) < 32'(w_elig_cnt)) begin
      w_limit = 3'(i_rec_available);
    end
    if (i_rec_full) begin
      w_limit = '0;
    end
  end

  tx_rr_packer u_packer (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .i_limit    (w_limit),
    .o_ids      (w_ids),
    .o_issued   (w_issued),
    .o_count    (w_count),
    .o_next_rr  (w_next_rr)
  );

  // Issue and arrival on the same source in one cycle cancel out. A
  // saturated counter cannot accept, so it can never wrap upward; an issued
  // counter is nonzero, so it can never wrap downward.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < NUM_TX_SOURCES; i++) begin
        r_pending[i] <= '0;
      end
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TX_SOURCES; i++) begin
        r_pending[i] <= r_pending[i] - PEND_WIDTH'(w_issued[i])
                                     + PEND_WIDTH'(w_accept[i]);
      end
      if (w_count != 3'd0) begin
        r_rr_ptr <= w_next_rr;
      end
      r_overflow <= r_overflow | (|(i_req_valid & ~w_ready));
    end
  end

  assign o_req_ready     = w_ready;
  assign o_rec_wr_en     = (w_count != 3'd0);
  assign o_rec_wr_mode   = w_count;
  assign o_rec_wr_data_1 = w_ids[0];
  assign o_rec_wr_data_2 = w_ids[1];
  assign o_rec_wr_data_3 = w_ids[2];
  assign o_rec_wr_data_4 = w_ids[3];
  assign o_overflow_err  = r_overflow;
  assign o_dbg_rr_ptr    = r_rr_ptr;

endmodule

// File: tb/tb_tx_arbiter_request_collector.sv
// ----------------------------------------------------------------------------
// tb_tx_arbiter_request_collector
//
// Directed steps in one initial block plus a short randomized phase driven
// through a small reference model. Every expected recorder write is pushed to
// exp_q when stimulus is driven; a negedge monitor pops and compares each
// write the DUT produces and flags any write nobody expected.
// ----------------------------------------------------------------------------
module tb_tx_arbiter_request_collector;
  import tx_arbiter_request_collector_pkg::*;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                arst;
  logic [3:0]          req_valid;
  logic [3:0]          req_ready;
  logic [4:0]          rec_available;
  logic                rec_full;
  logic                rec_wr_en;
  logic [2:0]          rec_wr_mode;
  Tx_Arbiter_Sources_t d1, d2, d3, d4;
  logic                overflow_err;
  logic [1:0]          rr_ptr;

  always #5 clk = ~clk;

  tx_arbiter_request_collector #(
    .FIFO_DEPTH (10),
    .PEND_WIDTH (4)
  ) dut (
    .i_clk           (clk),
    .i_arst          (arst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_rec_available (rec_available),
    .i_rec_full      (rec_full),
    .o_rec_wr_en     (rec_wr_en),
    .o_rec_wr_mode   (rec_wr_mode),
    .o_rec_wr_data_1 (d1),
    .o_rec_wr_data_2 (d2),
    .o_rec_wr_data_3 (d3),
    .o_rec_wr_data_4 (d4),
    .o_overflow_err  (overflow_err),
    .o_dbg_rr_ptr    (rr_ptr)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {mode[2:0], id1, id2, id3, id4}
  logic [14:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] wr_word(input int mode, input int a, input int b,
                                          input int c, input int d);
    return {3'(mode), 3'(a), 3'(b), 3'(c), 3'(d)};
  endfunction

  always @(negedge clk) begin
    if (!arst && rec_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {17'd0, rec_wr_mode, d1, d2, d3, d4}, 32'd0);
      end else begin
        chk("write", {17'd0, rec_wr_mode, d1, d2, d3, d4}, {17'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    req_valid = v;
    step();
    req_valid = '0;
  endtask

  // Reference model for the randomized phase.
  int   m_pend[4];
  int   m_rr;
  logic m_ovf;

  task automatic model_cycle(input logic [3:0] v, input int a, input logic f);
    int cnt, n, got, last, idx;
    int slot[4];
    logic [3:0] iss;
    req_valid     = v;
    rec_available = 5'(a);
    rec_full      = f;
    cnt = 0; got = 0; last = 0; iss = '0;
    for (int i = 0; i < 4; i++) begin
      slot[i] = 0;
      if (m_pend[i] != 0) cnt++;
    end
    n = (a < cnt) ? a : cnt;
    if (f) n = 0;
    for (int k = 0; k < 4; k++) begin
      idx = (m_rr + k) % 4;
      if (m_pend[idx] != 0 && got < n) begin
        slot[got] = idx + 1;
        iss[idx]  = 1'b1;
        last      = idx;
        got++;
      end
    end
    if (n > 0) begin
      exp_q.push_back(wr_word(n, slot[0], slot[1], slot[2], slot[3]));
      m_rr = (last + 1) % 4;
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i] && m_pend[i] == 15) m_ovf = 1'b1;
      m_pend[i] = m_pend[i] - int'(iss[i]) + ((v[i] && m_pend[i] != 15) ? 1 : 0);
    end
    step();
    req_valid = '0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    arst          = 1'b1;
    req_valid     = '0;
    rec_available = 5'd10;
    rec_full      = 1'b0;
    #1;
    chk("por_wr_en", 32'(rec_wr_en), 32'd0);
    chk("por_mode", 32'(rec_wr_mode), 32'd0);
    chk("por_ready", 32'(req_ready), 32'hF);
    chk("por_rr_ptr", 32'(rr_ptr), 32'd0);
    step();
    step();
    arst = 1'b0;

    // Reset mid-traffic with pending[MASTER] = 5
    rec_available = 5'd0;
    repeat (5) pulse(4'b0100);
    chk("rst_pre_ready", 32'(req_ready), 32'hF);
    chk("rst_pre_no_write", 32'(rec_wr_en), 32'd0);
    rec_available = 5'd10;
    #1;
    chk("rst_pre_write", {29'd0, d1}, {29'd0, MASTER});
    arst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(rec_wr_en), 32'd0);
    chk("rst_mode", 32'(rec_wr_mode), 32'd0);
    chk("rst_data", {20'd0, d1, d2, d3, d4}, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'hF);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    step();
    arst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_after_idle", 32'(rec_wr_en), 32'd0);
    end

    // All four simultaneous, rr_ptr = 0
    exp_q.push_back(wr_word(4, 1, 2, 3, 4));
    pulse(4'b1111);
    chk("all4_mode", 32'(rec_wr_mode), 32'd4);
    step();
    chk("all4_rr_ptr", 32'(rr_ptr), 32'd0);
    chk("all4_idle", 32'(rec_wr_en), 32'd0);

    // Space-limited
    rec_available = 5'd2;
    exp_q.push_back(wr_word(2, 1, 2, 0, 0));
    pulse(4'b1111);
    chk("space_mode", 32'(rec_wr_mode), 32'd2);
    chk("space_data", {20'd0, d1, d2, d3, d4}, {17'd0, wr_word(0, 1, 2, 0, 0)});
    exp_q.push_back(wr_word(2, 3, 4, 0, 0));
    step();
    rec_available = 5'd10;
    #1;
    chk("space_rr_ptr", 32'(rr_ptr), 32'd2);
    chk("space_mode2", 32'(rec_wr_mode), 32'd2);
    step();
    chk("space_rr_wrap", 32'(rr_ptr), 32'd0);
    chk("space_idle", 32'(rec_wr_en), 32'd0);

    // Single
    exp_q.push_back(wr_word(1, 1, 0, 0, 0));
    pulse(4'b0001);
    chk("single_wr_en", 32'(rec_wr_en), 32'd1);
    chk("single_data1", {29'd0, d1}, {29'd0, A2P_1});
    step();
    chk("single_idle", 32'(rec_wr_en), 32'd0);

    // Full hold for 5 cycles while A2P_2 pulses three times
    rec_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      pulse((c % 2 == 0) ? 4'b0010 : 4'b0000);
      chk("hold_no_write", 32'(rec_wr_en), 32'd0);
    end
    for (int c = 0; c < 3; c++) exp_q.push_back(wr_word(1, 2, 0, 0, 0));
    rec_full = 1'b0;
    #1;
    chk("hold_rel_1", {28'd0, rec_wr_en, d1}, {28'd1, A2P_2});
    step();
    chk("hold_rel_2", {28'd0, rec_wr_en, d1}, {28'd1, A2P_2});
    step();
    chk("hold_rel_3", {28'd0, rec_wr_en, d1}, {28'd1, A2P_2});
    step();
    chk("hold_done", 32'(rec_wr_en), 32'd0);

    // Overflow on MASTER with no recorder space
    rec_available = 5'd0;
    for (int p = 1; p <= 16; p++) begin
      pulse(4'b0100);
      if (p == 14) chk("ovf_ready_14", 32'(req_ready[2]), 32'd1);
      if (p == 15) begin
        chk("ovf_ready_15", 32'(req_ready[2]), 32'd0);
        chk("ovf_not_yet", 32'(overflow_err), 32'd0);
      end
      if (p == 16) chk("ovf_set", 32'(overflow_err), 32'd1);
    end
    repeat (3) step();
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    for (int c = 0; c < 15; c++) exp_q.push_back(wr_word(1, 3, 0, 0, 0));
    rec_available = 5'd10;
    repeat (15) step();
    chk("ovf_drain_count", 32'(exp_q.size()), 32'd0);
    chk("ovf_drain_idle", 32'(rec_wr_en), 32'd0);
    chk("ovf_still_set", 32'(overflow_err), 32'd1);

    // Reset clears the sticky flag
    arst = 1'b1;
    #1;
    chk("rst2_ovf", 32'(overflow_err), 32'd0);
    chk("rst2_ready", 32'(req_ready), 32'hF);
    step();
    arst = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_rr  = 0;
    m_ovf = 1'b0;
    for (int c = 0; c < 200; c++) begin
      model_cycle(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  $urandom_range(0, 10), ($urandom_range(0, 7) == 0));
    end
    for (int c = 0; c < 20; c++) model_cycle(4'b0000, 10, 1'b0);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_idle", 32'(rec_wr_en), 32'd0);
    chk("rand_ovf", 32'(overflow_err), 32'(m_ovf));
    chk("rand_rr_ptr", 32'(rr_ptr), 32'(m_rr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
